bullet_scheduler: RTL and testbench
===================================

BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 Parameter NUM_BULLETS, default 3: number of bullet slots managed.
REQ-002 Parameter COOLDOWN_FRAMES, default 8: move pulses that must elapse between shots.
REQ-003 Parameter FIRE_OFFSET_Y, default 20: vertical offset in pixels from the ship to the spawn point.
REQ-004 clk  input  1  system clock, 100 MHz; the only clock in the block.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 move  input  1  one-cycle frame-update pulse from the game timing.
REQ-007 shoot  input  1  raw fire button; asynchronous to clk.
REQ-008 ship_x  input  10  current ship X location.
REQ-009 ship_y  input  10  current ship Y location.
REQ-010 bullet_done  input  NUM_BULLETS  per-slot pulse: bullet hit something or left the screen.
REQ-011 fire  output  NUM_BULLETS  one-hot, one-cycle launch strobe to the bullet instance.
REQ-012 fire_x  output  10  registered spawn X, valid while any fire bit is high and held afterwards.
REQ-013 fire_y  output  10  registered spawn Y, valid while any fire bit is high and held afterwards.
REQ-014 active  output  NUM_BULLETS  slot-in-flight flags.
REQ-015 bullet_count  output  2  population count of active.
REQ-016 ready  output  1  high when the FSM is in READY.

Function
REQ-017 shoot SHALL pass through a two-flop synchronizer; a press SHALL be detected as a rising edge of the synchronized signal.
REQ-018 The FSM SHALL have exactly two states, READY and COOLDOWN.
REQ-019 In READY, a detected press with at least one active bit clear SHALL:
  - select the lowest-index free slot;
  - pulse fire on that slot for one cycle;
  - set that slot's active bit;
  - load the cooldown counter with COOLDOWN_FRAMES;
  - go to COOLDOWN.
REQ-020 Latency: fire SHALL be high in the third clk cycle after the first clk edge that samples shoot high (two synchronizer stages plus a registered output).
REQ-021 On the fire cycle, fire_x SHALL equal ship_x and fire_y SHALL equal ship_y - FIRE_OFFSET_Y, both taken from the same clk edge.
REQ-022 fire_y SHALL saturate at 0 when ship_y < FIRE_OFFSET_Y.
REQ-023 A press detected while all slots are active, or while in COOLDOWN, SHALL be discarded: no fire pulse, and the press is not queued.
REQ-024 Holding shoot high SHALL produce only one shot; a second shot requires release and re-press.
REQ-025 In COOLDOWN, the counter SHALL decrement once per move pulse, and the FSM SHALL return to READY on the cycle after the counter reaches 0.
REQ-026 COOLDOWN_FRAMES = 0 SHALL return the FSM to READY on the next cycle.
REQ-027 bullet_done[i] SHALL clear active[i] at the next clk edge.
REQ-028 bullet_done on a slot that is already inactive SHALL be ignored.
REQ-029 Allocation SHALL use the registered active value: a slot freed by bullet_done in the same cycle as a press SHALL NOT be chosen in that cycle.
REQ-030 A simultaneous bullet_done on slot i and fire on slot j SHALL apply both.
REQ-031 bullet_count SHALL always equal the number of set active bits, in the same cycle as active.

Reset
REQ-032 While rst is high:
  - fire = 0, active = 0, bullet_count = 0;
  - fire_x = 0, fire_y = 0;
  - cooldown counter = 0;
  - synchronizer and edge flops = 0;
  - FSM = READY, ready = 1.
REQ-033 Reset asserted mid-COOLDOWN or mid-flight SHALL abandon all state. The first press after reset deasserts SHALL be accepted normally.
REQ-034 A shoot level that is already high when reset releases SHALL NOT count as a press.

Structure
REQ-035 The shared game package SHALL hold:
  - the FSM state encoding;
  - the screen coordinate width (10);
  - the default NUM_BULLETS;
  - the default FIRE_OFFSET_Y.
REQ-036 One sub-module, press_detect (synchronizer plus rising-edge pulse), SHALL be instantiated. Slot selection SHALL be a parameterized priority encoder inside bullet_scheduler.

Verification
REQ-037 Reset release, ship_x=270, ship_y=400, shoot pulsed high for 10 cycles -> exactly one fire=3'b001 at the third cycle after the first sampled high; fire_x=270, fire_y=380; active=3'b001; count=1.
REQ-038 Three presses separated by 9 move pulses -> fire sequence 001, 010, 100; count=3. A fourth press -> no fire, active unchanged.
REQ-039 active=3'b111, bullet_done=3'b010 in the same cycle as a press -> no fire that cycle. After the next press (READY), fire=3'b010.
REQ-040 Press, then a second press after only 3 move pulses -> second press ignored. A press after the 8th move pulse -> fires.
REQ-041 ship_y=5 on press -> fire_y=0.
REQ-042 rst asserted at cooldown count 4 with active=3'b011 -> all outputs return to reset values immediately (asynchronously). The first press after release fires slot 0.

Source files
------------

// File: rtl/bullet_scheduler_pkg.sv
// rtl/bullet_scheduler_pkg.sv - shared game types, widths and defaults for the bullet scheduler
package bullet_scheduler_pkg;

  localparam int COORD_W               = 10;
  localparam int DEFAULT_NUM_BULLETS   = 3;
  localparam int DEFAULT_FIRE_OFFSET_Y = 20;

  typedef enum logic {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } sched_state_e;

  // Spawn point sits above the ship; clamp at the top edge of the screen.
  function automatic logic [COORD_W-1:0] spawn_y(input logic [COORD_W-1:0] y, input int offset);
    if (int'(y) < offset) return '0;
    return y - COORD_W'(offset);
  endfunction

endpackage

// File: rtl/bullet_scheduler_press_detect.sv
// rtl/bullet_scheduler_press_detect.sv - two-flop synchronizer plus rising-edge press pulse
module press_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q, edge_d;
  logic vld1_q, vld1_d;
  logic vld2_q, vld2_d;
  logic armed_q, armed_d;

  // armed only after a genuine low sample, so a button held through reset is not a press
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    vld1_d  = 1'b1;
    vld2_d  = vld1_q;
    armed_d = armed_q | (vld2_q & ~sync2_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      vld1_q  <= vld1_d;
      vld2_q  <= vld2_d;
      armed_q <= armed_d;
    end
  end

  assign press = armed_q & sync2_q & ~edge_q;

endmodule

// File: rtl/bullet_scheduler.sv
// rtl/bullet_scheduler.sv - allocates bullet slots on button presses with a move-paced cooldown
module bullet_scheduler
  import bullet_scheduler_pkg::*;
#(
  parameter int NUM_BULLETS     = DEFAULT_NUM_BULLETS,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int FIRE_OFFSET_Y   = DEFAULT_FIRE_OFFSET_Y
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move,
  input  logic                   shoot,
  input  logic [COORD_W-1:0]     ship_x,
  input  logic [COORD_W-1:0]     ship_y,
  input  logic [NUM_BULLETS-1:0] bullet_done,
  output logic [NUM_BULLETS-1:0] fire,
  output logic [COORD_W-1:0]     fire_x,
  output logic [COORD_W-1:0]     fire_y,
  output logic [NUM_BULLETS-1:0] active,
  output logic [1:0]             bullet_count,
  output logic                   ready
);

  localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  sched_state_e           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_BULLETS-1:0] active_q, active_d;
  logic [NUM_BULLETS-1:0] fire_q, fire_d;
  logic [COORD_W-1:0]     fire_x_q, fire_x_d;
  logic [COORD_W-1:0]     fire_y_q, fire_y_d;
  logic [NUM_BULLETS-1:0] free_onehot;
  logic                   found;
  logic                   any_free;
  logic                   press;
  logic [1:0]             pop;

  press_detect u_press_detect (
    .clk   (clk),
    .rst   (rst),
    .din   (shoot),
    .press (press)
  );

  // Lowest-index free slot, judged on the registered flags only.
  always_comb begin
    free_onehot = '0;
    found       = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!active_q[i] && !found) begin
        free_onehot[i] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign any_free = ~&active_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fire_d   = '0;
    fire_x_d = fire_x_q;
    fire_y_d = fire_y_q;
    case (state_q)
      ST_READY: begin
        if (press && any_free) begin
          fire_d   = free_onehot;
          fire_x_d = ship_x;
          fire_y_d = spawn_y(ship_y, FIRE_OFFSET_Y);
          cnt_d    = CNT_W'(COOLDOWN_FRAMES);
          state_d  = ST_COOLDOWN;
        end
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0) state_d = ST_READY;
        else if (move)   cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_READY;
    endcase
    active_d = (active_q & ~bullet_done) | fire_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_READY;
      cnt_q    <= '0;
      active_q <= '0;
      fire_q   <= '0;
      fire_x_q <= '0;
      fire_y_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      fire_q   <= fire_d;
      fire_x_q <= fire_x_d;
      fire_y_q <= fire_y_d;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_BULLETS; i++) pop = pop + 2'(active_q[i]);
  end

  assign fire         = fire_q;
  assign fire_x       = fire_x_q;
  assign fire_y       = fire_y_q;
  assign active       = active_q;
  assign bullet_count = pop;
  assign ready        = (state_q == ST_READY);

endmodule

// File: tb/tb_bullet_scheduler.sv
// tb/tb_bullet_scheduler.sv - table-driven and scoreboard bench for bullet_scheduler
module tb_bullet_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move = 1'b0;
  logic       shoot = 1'b0;
  logic [9:0] ship_x = '0;
  logic [9:0] ship_y = '0;
  logic [2:0] bullet_done = '0;
  logic [2:0] fire;
  logic [9:0] fire_x;
  logic [9:0] fire_y;
  logic [2:0] active;
  logic [1:0] bullet_count;
  logic       ready;

  bullet_scheduler #(
    .NUM_BULLETS     (3),
    .COOLDOWN_FRAMES (8),
    .FIRE_OFFSET_Y   (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .move         (move),
    .shoot        (shoot),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .bullet_done  (bullet_done),
    .fire         (fire),
    .fire_x       (fire_x),
    .fire_y       (fire_y),
    .active       (active),
    .bullet_count (bullet_count),
    .ready        (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] done;
    int         moves;
    logic [2:0] exp_fire;
    logic [2:0] exp_active;
    logic [1:0] exp_count;
    logic       exp_ready;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] fire;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [9:0] model_y(input logic [9:0] y);
    if (y < 10'd20) return 10'd0;
    return y - 10'd20;
  endfunction

  always @(negedge clk) begin
    if (!rst && fire != 3'b000) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_fire: got fire=%b at cycle %0d, required no fire", fire, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("fire_cycle", cyc, mon_e.cyc);
        check("fire_onehot", {29'd0, fire}, {29'd0, mon_e.fire});
        check("fire_x", {22'd0, fire_x}, {22'd0, mon_e.x});
        check("fire_y", {22'd0, fire_y}, {22'd0, mon_e.y});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_moves(input int n);
    for (int k = 0; k < n; k++) begin
      move = 1'b1;
      tick();
      move = 1'b0;
      tick();
    end
  endtask

  task automatic expect_fire(input logic [2:0] f, input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e.cyc  = cyc + 3;
    e.fire = f;
    e.x    = x;
    e.y    = model_y(y);
    sb.push_back(e);
  endtask

  task automatic do_press(input logic [9:0] x, input logic [9:0] y, input logic [2:0] f);
    ship_x = x;
    ship_y = y;
    shoot  = 1'b1;
    if (f != 3'b000) expect_fire(f, x, y);
    repeat (10) tick();
    shoot = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_state(input string tag, input logic [2:0] a, input logic [1:0] c, input logic r);
    check({tag, "_active"}, {29'd0, active}, {29'd0, a});
    check({tag, "_count"}, {30'd0, bullet_count}, {30'd0, c});
    check({tag, "_ready"}, {31'd0, ready}, {31'd0, r});
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fire"}, {29'd0, fire}, 0);
    check({tag, "_fire_x"}, {22'd0, fire_x}, 0);
    check({tag, "_fire_y"}, {22'd0, fire_y}, 0);
    check({tag, "_active"}, {29'd0, active}, 0);
    check({tag, "_count"}, {30'd0, bullet_count}, 0);
    check({tag, "_ready"}, {31'd0, ready}, 1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    //             x       y       done    mv  fire    active  cnt   rdy
    vecs[0] = '{10'd270, 10'd400, 3'b000, 0, 3'b001, 3'b001, 2'd1, 1'b0};
    vecs[1] = '{10'd100, 10'd50,  3'b000, 3, 3'b000, 3'b001, 2'd1, 1'b0};
    vecs[2] = '{10'd100, 10'd50,  3'b000, 5, 3'b010, 3'b011, 2'd2, 1'b0};
    vecs[3] = '{10'd5,   10'd5,   3'b000, 9, 3'b100, 3'b111, 2'd3, 1'b0};
    vecs[4] = '{10'd600, 10'd479, 3'b000, 9, 3'b000, 3'b111, 2'd3, 1'b1};
    vecs[5] = '{10'd7,   10'd20,  3'b010, 9, 3'b010, 3'b111, 2'd3, 1'b0};
    vecs[6] = '{10'd8,   10'd90,  3'b101, 0, 3'b000, 3'b010, 2'd1, 1'b0};
    vecs[7] = '{10'd1023, 10'd21, 3'b000, 9, 3'b001, 3'b011, 2'd2, 1'b0};
    vecs[8] = '{10'd300, 10'd300, 3'b100, 9, 3'b100, 3'b111, 2'd3, 1'b0};

    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].done != 3'b000) begin
        bullet_done = vecs[i].done;
        tick();
        bullet_done = 3'b000;
        tick();
      end
      pulse_moves(vecs[i].moves);
      do_press(vecs[i].x, vecs[i].y, vecs[i].exp_fire);
      check_state($sformatf("vec%0d", i), vecs[i].exp_active, vecs[i].exp_count, vecs[i].exp_ready);
    end

    // Slot freed in the same cycle as a press must not be taken that cycle.
    do_reset();
    do_press(10'd1, 10'd100, 3'b001);
    pulse_moves(9);
    do_press(10'd2, 10'd100, 3'b010);
    pulse_moves(9);
    do_press(10'd3, 10'd100, 3'b100);
    pulse_moves(9);
    check_state("full", 3'b111, 2'd3, 1'b1);
    ship_x = 10'd11;
    ship_y = 10'd30;
    shoot  = 1'b1;
    tick();
    tick();
    bullet_done = 3'b010;
    tick();
    bullet_done = 3'b000;
    repeat (5) tick();
    shoot = 1'b0;
    repeat (3) tick();
    check_state("same_cycle_free", 3'b101, 2'd2, 1'b1);
    do_press(10'd12, 10'd40, 3'b010);
    check_state("refill", 3'b111, 2'd3, 1'b0);

    // Held button fires once; then reset lands mid-cooldown with two bullets in flight.
    do_reset();
    ship_x = 10'd50;
    ship_y = 10'd60;
    shoot  = 1'b1;
    expect_fire(3'b001, 10'd50, 10'd60);
    repeat (4) tick();
    pulse_moves(10);
    repeat (4) tick();
    shoot = 1'b0;
    repeat (3) tick();
    check_state("hold", 3'b001, 2'd1, 1'b1);
    do_press(10'd200, 10'd300, 3'b010);
    pulse_moves(4);
    check_state("mid_cooldown", 3'b011, 2'd2, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    do_press(10'd321, 10'd123, 3'b001);
    check_state("after_reset", 3'b001, 2'd1, 1'b0);

    // Button already held when reset releases is not a press.
    rst   = 1'b1;
    shoot = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    shoot = 1'b0;
    repeat (4) tick();
    check_state("held_through_reset", 3'b000, 2'd0, 1'b1);
    do_press(10'd99, 10'd19, 3'b001);
    check_state("first_real_press", 3'b001, 2'd1, 1'b0);

    repeat (3) tick();
    check("final_sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
